// File: rtl/mux_1b_8to1_pkg.sv
// ============================================================================
// Module   : mux_1b_8to1_pkg
// Brief    : Shared constants and types for the 1-bit 8-to-1 selector.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mux_1b_8to1_pkg;

  localparam int N_IN  = 8;
  localparam int SEL_W = 3;

  typedef logic [SEL_W-1:0] sel_t;

endpackage : mux_1b_8to1_pkg

`default_nettype wire

// File: rtl/mux_1b_8to1_dec.sv
// ============================================================================
// Module   : mux_1b_8to1_dec
// Brief    : 3-to-8 one-hot decoder; bit k is set when sel equals k.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mux_1b_8to1_dec
  import mux_1b_8to1_pkg::*;
(
  input  logic [SEL_W-1:0] sel,
  output logic [N_IN-1:0]  onehot
);

  // An X/Z on sel propagates to the compare result rather than being masked.
  for (genvar k = 0; k < N_IN; k++) begin : g_dec
    assign onehot[k] = (sel == sel_t'(k));
  end

endmodule : mux_1b_8to1_dec

`default_nettype wire

// File: rtl/mux_1b_8to1.sv
// ============================================================================
// Module   : mux_1b_8to1
// Brief    : 1-bit 8-to-1 selector with one-hot select sideband; optional
//            registered output enabled by MUX_1B_8TO1_OUT_REG_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mux_1b_8to1
  import mux_1b_8to1_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             in0,
  input  logic             in1,
  input  logic             in2,
  input  logic             in3,
  input  logic             in4,
  input  logic             in5,
  input  logic             in6,
  input  logic             in7,
  input  logic [SEL_W-1:0] sel,
  output logic             out,
  output logic [N_IN-1:0]  sel_onehot,
  output logic             out_q
);

  logic [N_IN-1:0] w_in_vec;
  logic [N_IN-1:0] w_onehot;

  assign w_in_vec = {in7, in6, in5, in4, in3, in2, in1, in0};

  mux_1b_8to1_dec u_dec (
    .sel    (sel),
    .onehot (w_onehot)
  );

  // AND-OR select: only the decoded input can reach out.
  assign out        = |(w_onehot & w_in_vec);
  assign sel_onehot = w_onehot;

`ifdef MUX_1B_8TO1_OUT_REG_EN
  logic r_out_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_out_q <= 1'b0;
    end else begin
      r_out_q <= out;
    end
  end

  assign out_q = r_out_q;
`else
  logic w_unused_clk_reset;

  assign w_unused_clk_reset = clk ^ reset;
  assign out_q              = 1'b0;
`endif

endmodule : mux_1b_8to1

`default_nettype wire

// File: tb/tb_mux_1b_8to1.sv
// ============================================================================
// Module   : tb_mux_1b_8to1
// Brief    : Self-checking bench for mux_1b_8to1 (either build of
//            MUX_1B_8TO1_OUT_REG_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mux_1b_8to1;

  typedef struct packed {
    logic       out;
    logic [7:0] oh;
    logic       q;
  } exp_t;

  logic       clk;
  logic       reset;
  logic [7:0] in_vec;
  logic [2:0] sel;
  logic       out;
  logic [7:0] sel_onehot;
  logic       out_q;

  exp_t       sb[$];
  int         checks;
  int         failures;
  logic       cur_out;
  logic       m_q;

  mux_1b_8to1 dut (
    .clk        (clk),
    .reset      (reset),
    .in0        (in_vec[0]),
    .in1        (in_vec[1]),
    .in2        (in_vec[2]),
    .in3        (in_vec[3]),
    .in4        (in_vec[4]),
    .in5        (in_vec[5]),
    .in6        (in_vec[6]),
    .in7        (in_vec[7]),
    .sel        (sel),
    .out        (out),
    .sel_onehot (sel_onehot),
    .out_q      (out_q)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference for the registered output: previous cycle's expected out.
  always @(posedge clk or negedge reset) begin
    if (!reset) m_q <= 1'b0;
    else        m_q <= cur_out;
  end

  function automatic logic exp_q();
`ifdef MUX_1B_8TO1_OUT_REG_EN
    return m_q;
`else
    return 1'b0;
`endif
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Drive just after the rising edge, push the expectation, check mid-cycle.
  task automatic step(input logic [7:0] v, input logic [2:0] s, input string tag);
    exp_t e;
    exp_t got;
    @(posedge clk);
    #1;
    in_vec  = v;
    sel     = s;
    cur_out = v[s];
    e.out   = v[s];
    e.oh    = 8'd1 << s;
    e.q     = exp_q();
    sb.push_back(e);
    @(negedge clk);
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s scoreboard empty", tag);
    end else begin
      got = sb.pop_front();
      chk({tag, "_out"}, {7'd0, out}, {7'd0, got.out});
      chk({tag, "_onehot"}, sel_onehot, got.oh);
      chk({tag, "_out_q"}, {7'd0, out_q}, {7'd0, got.q});
    end
  endtask

  initial begin
    logic [7:0] v;
    checks   = 0;
    failures = 0;
    cur_out  = 1'b0;
    reset    = 1'b0;
    in_vec   = 8'h00;
    sel      = 3'd0;

    #2;
    chk("reset_out_q", {7'd0, out_q}, 8'h00);
    chk("reset_out", {7'd0, out}, 8'h00);
    chk("reset_onehot", sel_onehot, 8'h01);
    in_vec = 8'h10;
    sel    = 3'd4;
    #1;
    chk("reset_out_live", {7'd0, out}, 8'h01);
    in_vec = 8'h00;
    sel    = 3'd0;
    @(negedge clk);
    reset = 1'b1;

    for (int k = 0; k < 8; k++) step(8'h00, 3'(k), "zero_sweep");

    for (int k = 0; k < 8; k++) begin
      v = 8'd1 << k;
      step(v, 3'(k), "only_k_set");
      step(8'h00, 3'(k), "only_k_clear");
    end

    for (int k = 0; k < 8; k++) begin
      if (k != 3) begin
        v = 8'd1 << k;
        step(v, 3'd3, "unselected_walk");
      end
    end
    step(8'h80, 3'd3, "in7_only");
    step(8'h88, 3'd3, "in3_set");

    for (int i = 0; i < 20; i++) step(8'($urandom), 3'($urandom_range(7, 0)), "random");

    step(8'h01, 3'd0, "pre_reset_a");
    step(8'h01, 3'd0, "pre_reset_b");
    #2;
    reset = 1'b0;
    #1;
    chk("midreset_out_q", {7'd0, out_q}, 8'h00);
    chk("midreset_out", {7'd0, out}, 8'h01);
    @(posedge clk);
    #1;
    chk("midreset_held_q", {7'd0, out_q}, 8'h00);
    @(negedge clk);
    reset = 1'b1;

    step(8'h00, 3'd0, "post_reset_a");
    step(8'hFF, 3'd5, "post_reset_b");
    step(8'h20, 3'd5, "post_reset_c");
    step(8'hDF, 3'd5, "post_reset_d");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_mux_1b_8to1

`default_nettype wire
